// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Purpose  : Runs a multi-pass command against an external combinational
//             ALU.  The accumulator is fed back as op1 on every pass, op2
//             is held constant.  DEC/DECx-style opcodes (00101, 00110) stop
//             early as soon as the ALU reports a negative result.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             cmd_*               - valid/ready command channel
//             alu_opcode/op1/op2  - operands driven to the ALU (0 unless EXEC)
//             alu_res/s/g         - ALU result and flags (sampled in EXEC only)
//             rsp_*               - valid/ready registered response channel
//  Revision : 1.0  initial release
// ============================================================================
module alu_sequencer #(
    parameter int ITER_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_opcode,
    input  logic [9:0]        cmd_op1,
    input  logic [9:0]        cmd_op2,
    input  logic [ITER_W-1:0] cmd_iter,
    output logic [4:0]        alu_opcode,
    output logic [9:0]        alu_op1,
    output logic [9:0]        alu_op2,
    input  logic [9:0]        alu_res,
    input  logic              alu_s,
    input  logic              alu_g,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [9:0]        rsp_res,
    output logic              rsp_s,
    output logic              rsp_g,
    output logic              rsp_err,
    output logic              rsp_early
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [4:0]          r_opcode;
    logic [9:0]          r_acc;
    logic [9:0]          r_op2;
    logic [ITER_W-1:0]   r_cnt;

    // Handshake outputs are registered so that they read 0 while reset is
    // asserted even though the reset state is IDLE.
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic [9:0]          r_rsp_res;
    logic                r_rsp_s;
    logic                r_rsp_g;
    logic                r_rsp_err;
    logic                r_rsp_early;

    logic                w_accept;
    logic                w_supported;
    logic                w_early_op;
    logic                w_early_stop;
    logic                w_last_pass;

    assign w_accept     = cmd_valid && r_cmd_ready;
    assign w_early_op   = (r_opcode == 5'b00101) || (r_opcode == 5'b00110);
    assign w_early_stop = w_early_op && alu_s;
    assign w_last_pass  = (r_cnt == '0) || w_early_stop;

    always_comb begin
        w_supported = 1'b0;
        case (cmd_opcode)
            5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
            5'b01010, 5'b01011, 5'b01100, 5'b10011: w_supported = 1'b1;
            default:                                w_supported = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept)                 w_next = w_supported ? EXEC : RESP;
            EXEC: if (w_last_pass)              w_next = RESP;
            RESP: if (r_rsp_valid && rsp_ready) w_next = IDLE;
            default:                            w_next = IDLE;
        endcase
    end

    // ALU is only driven while a pass is executing
    assign alu_opcode = (r_state == EXEC) ? r_opcode : 5'd0;
    assign alu_op1    = (r_state == EXEC) ? r_acc    : 10'd0;
    assign alu_op2    = (r_state == EXEC) ? r_op2    : 10'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_opcode    <= '0;
            r_acc       <= '0;
            r_op2       <= '0;
            r_cnt       <= '0;
            r_rsp_res   <= '0;
            r_rsp_s     <= 1'b0;
            r_rsp_g     <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_early <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == IDLE);
            r_rsp_valid <= (w_next == RESP);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_opcode <= cmd_opcode;
                        r_acc    <= cmd_op1;
                        r_op2    <= cmd_op2;
                        r_cnt    <= cmd_iter;
                        if (!w_supported) begin
                            r_rsp_res   <= '0;
                            r_rsp_s     <= 1'b0;
                            r_rsp_g     <= 1'b0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_early <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    r_acc <= alu_res;
                    // Response registers are loaded only on the final pass so
                    // they keep their previous value outside RESP.
                    if (w_last_pass) begin
                        r_rsp_res   <= alu_res;
                        r_rsp_s     <= alu_s;
                        r_rsp_g     <= alu_g;
                        r_rsp_err   <= 1'b0;
                        r_rsp_early <= w_early_stop;
                    end else begin
                        r_cnt <= r_cnt - ITER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_res   = r_rsp_res;
    assign rsp_s     = r_rsp_s;
    assign rsp_g     = r_rsp_g;
    assign rsp_err   = r_rsp_err;
    assign rsp_early = r_rsp_early;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_sequencer
//  Purpose  : Directed self-checking bench for alu_sequencer, with a small
//             behavioural ALU (DEC, XOR, INC) closing the operand loop.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int ITER_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [4:0]        cmd_opcode;
    logic [9:0]        cmd_op1;
    logic [9:0]        cmd_op2;
    logic [ITER_W-1:0] cmd_iter;
    logic [4:0]        alu_opcode;
    logic [9:0]        alu_op1;
    logic [9:0]        alu_op2;
    logic [9:0]        alu_res;
    logic              alu_s;
    logic              alu_g;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [9:0]        rsp_res;
    logic              rsp_s;
    logic              rsp_g;
    logic              rsp_err;
    logic              rsp_early;

    int checks   = 0;
    int failures = 0;
    int lat;
    logic       alu_seen;
    logic [4:0] first_op;
    logic [9:0] first_op1;
    logic [9:0] first_op2;

    always #5 clk = ~clk;

    alu_sequencer #(.ITER_W(ITER_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_op1    (cmd_op1),
        .cmd_op2    (cmd_op2),
        .cmd_iter   (cmd_iter),
        .alu_opcode (alu_opcode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_res    (alu_res),
        .alu_s      (alu_s),
        .alu_g      (alu_g),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_res    (rsp_res),
        .rsp_s      (rsp_s),
        .rsp_g      (rsp_g),
        .rsp_err    (rsp_err),
        .rsp_early  (rsp_early)
    );

    always_comb begin
        alu_res = 10'd0;
        case (alu_opcode)
            5'b00101: alu_res = alu_op1 - 10'd1;
            5'b00111: alu_res = alu_op1 ^ alu_op2;
            5'b10011: alu_res = alu_op1 + 10'd1;
            default:  alu_res = 10'd0;
        endcase
        alu_s = alu_res[9];
        alu_g = ($signed(alu_op1) > $signed(alu_op2));
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [4:0] op, input logic [9:0] a,
                           input logic [9:0] b, input logic [ITER_W-1:0] it);
        cmd_opcode = op;
        cmd_op1    = a;
        cmd_op2    = b;
        cmd_iter   = it;
        cmd_valid  = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat       = 1;
        first_op  = alu_opcode;
        first_op1 = alu_op1;
        first_op2 = alu_op2;
        alu_seen  = (alu_opcode != 5'd0);
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            alu_seen = alu_seen | (alu_opcode != 5'd0);
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("handshake_rsp_valid_low", rsp_valid, 1'b0);
        check("handshake_cmd_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_op1    = '0;
        cmd_op2    = '0;
        cmd_iter   = '0;
        rsp_ready  = 1'b0;

        #7;
        check("reset_cmd_ready", cmd_ready, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_alu_opcode", alu_opcode, 5'd0);
        check("reset_rsp_res", rsp_res, 10'd0);
        #15 rst_n = 1'b1;
        #1;
        check("pre_edge_cmd_ready", cmd_ready, 1'b0);
        @(posedge clk); #1;
        check("first_edge_cmd_ready", cmd_ready, 1'b1);

        run_cmd(5'b00111, 10'h155, 10'h0FF, 3'd0);
        check("xor_alu_opcode", first_op, 5'b00111);
        check("xor_alu_op1", first_op1, 10'h155);
        check("xor_alu_op2", first_op2, 10'h0FF);
        check("xor_latency", lat, 2);
        check("xor_res", rsp_res, 10'h1AA);
        check("xor_s", rsp_s, 1'b0);
        check("xor_g", rsp_g, 1'b1);
        check("xor_err", rsp_err, 1'b0);
        check("xor_early", rsp_early, 1'b0);
        take_rsp();

        run_cmd(5'b10011, 10'd510, 10'd0, 3'd3);
        check("inc_latency", lat, 5);
        check("inc_res", rsp_res, 10'h202);
        check("inc_s", rsp_s, 1'b1);
        check("inc_g", rsp_g, 1'b0);
        check("inc_early", rsp_early, 1'b0);
        take_rsp();

        run_cmd(5'b00101, 10'd2, 10'd0, 3'd7);
        check("dec_latency", lat, 4);
        check("dec_res", rsp_res, 10'h3FF);
        check("dec_s", rsp_s, 1'b1);
        check("dec_g", rsp_g, 1'b0);
        check("dec_early", rsp_early, 1'b1);

        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rsp_res", rsp_res, 10'h3FF);
            check("bp_rsp_early", rsp_early, 1'b1);
            check("bp_cmd_ready", cmd_ready, 1'b0);
        end
        take_rsp();

        run_cmd(5'b00000, 10'h123, 10'h045, 3'd5);
        check("err_latency", lat, 1);
        check("err_flag", rsp_err, 1'b1);
        check("err_res", rsp_res, 10'd0);
        check("err_s", rsp_s, 1'b0);
        check("err_early", rsp_early, 1'b0);
        check("err_alu_driven", alu_seen, 1'b0);
        take_rsp();

        cmd_opcode = 5'b00101;
        cmd_op1    = 10'd100;
        cmd_op2    = 10'd0;
        cmd_iter   = 3'd7;
        cmd_valid  = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_alu_op1_before", alu_op1, 10'd98);
        #2 rst_n = 1'b0;
        #1;
        check("abort_alu_opcode", alu_opcode, 5'd0);
        check("abort_alu_op1", alu_op1, 10'd0);
        check("abort_cmd_ready", cmd_ready, 1'b0);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_rsp_err", rsp_err, 1'b0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_cmd_ready_after", cmd_ready, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("abort_no_rsp", rsp_valid, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
